rv_pipe_ctrl: RTL and testbench
===============================

RV_PIPE_CTRL -- requirements
Module: rv_pipe_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the PC/data width.
REQ-002 The block SHALL have parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h00000013, the bubble encoding.
REQ-004 The block SHALL have parameter CNT_W, default 16, the performance-counter width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 f_pc  in  XLEN  fetch PC.
REQ-008 f_instr  in  32  fetched instruction.
REQ-009 br_taken  in  1  X-stage redirect (branch taken or jump); valid only when x_valid=1.
REQ-010 dmem_ready  in  1  data memory handshake; 0 = M-stage access not complete.
REQ-011 pc_stall  out  1  hold PC and fetch.
REQ-012 d_pc/x_pc/m_pc  out  XLEN  stage PCs.
REQ-013 d_instr/x_instr/m_instr/w_instr  out  32  stage instructions.
REQ-014 d_valid/x_valid/m_valid/w_valid  out  1  stage occupancy.
REQ-015 fwd_a_sel/fwd_b_sel  out  2  X operand source: 0 = regfile, 1 = M-stage ALU result, 2 = W-stage writeback.
REQ-016 stall_cnt/flush_cnt  out  CNT_W  performance counters.

Function
REQ-017 Decode rules:
- "writes rd": opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111, with rd != 0.
- "uses rs1": R, I-ALU, load, store, branch, JALR.
- "uses rs2": R, store, branch.
REQ-018 On a normal advance, F->D->X->M->W SHALL move one stage per cycle, carrying instr, pc and valid.
REQ-019 Memory wait:
- Condition: m_valid=1, m_instr is a load/store, and dmem_ready=0.
- D, X and M SHALL hold; pc_stall=1; W receives a bubble.
REQ-020 Load-use (FWD_EN=1):
- Condition: x_valid=1, X is a load, and a D source that is used equals x rd.
- F and D SHALL hold for one cycle; X receives a bubble; pc_stall=1.
REQ-021 Stall-only hazard (FWD_EN=0): whenever a used D source equals the rd of a valid writing instruction in X, M or W, F and D SHALL hold, X receives a bubble, and pc_stall=1.
REQ-022 Forwarding (FWD_EN=1): for each X source, the select SHALL be 1 if the M-stage instruction is valid, writes rd and matches; else 2 if the W-stage instruction does; else 0.
- M has priority over W.
- Register x0 is never forwarded.
REQ-023 With FWD_EN=0, fwd_a_sel and fwd_b_sel SHALL be constant 0.
REQ-024 Flush: br_taken=1 with x_valid=1 SHALL bubble D and X on the next edge; pc_stall=0 that cycle.
REQ-025 Bubble: instr=NOP_INSTR, valid=0, pc unchanged.
REQ-026 Priority: memory wait > flush > load-use/hazard stall. During a memory wait the flush is deferred; X still holds the branch, which re-asserts br_taken.
REQ-027 All control outputs SHALL be combinational from current stage registers and inputs; stage registers SHALL update with zero added latency.
REQ-028 stall_cnt SHALL increment each cycle pc_stall=1, and flush_cnt each flush edge, both saturating at all-ones.

Reset
REQ-029 While rst=1 at a clock edge, the following SHALL take effect next cycle:
- all valid = 0, all instr = NOP_INSTR, all pc = 0;
- counters = 0, pc_stall = 0, fwd selects = 0.
REQ-030 rst asserted mid-stall or mid-wait SHALL override all hold and flush logic.

Structure
REQ-031 Opcode constants, NOP_INSTR default and forward-select encodings SHALL live in shared package rv_pkg.
REQ-032 A single sub-module rv_hazard_detect SHALL hold the combinational decode, match, forward and stall logic; rv_pipe_ctrl holds the stage registers and counters.

Verification
REQ-033 add x1,x2,x3 followed by sub x4,x1,x5 (FWD_EN=1) -> when sub is in X, fwd_a_sel=1, no stall, stall_cnt stays 0.
REQ-034 lw x6,0(x0) followed by add x7,x6,x6 -> pc_stall=1 for exactly 1 cycle, x_instr=0x00000013 with x_valid=0, then fwd_a_sel=fwd_b_sel=2.
REQ-035 beq in X with br_taken=1 -> next cycle d_valid=0, x_valid=0, flush_cnt=1; a following br_taken with x_valid=0 is ignored.
REQ-036 sw in M with dmem_ready=0 for 3 cycles -> D/X/M held 3 cycles, w_valid=0, stall_cnt=3; advance on the 4th.
REQ-037 FWD_EN=0: add x1 then or x2,x1,x1 -> 3 stall cycles, fwd selects stay 0.
REQ-038 rst pulsed during the REQ-036 wait -> next cycle all valid=0, counters=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 decode constants and helpers for the pipeline control slice.
package rv_pkg;

    // Major opcodes the pipeline control needs to recognise
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    // X-stage operand source
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    function automatic logic [4:0] rd_of(input logic [31:0] i);
        return i[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] i);
        return i[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] i);
        return i[24:20];
    endfunction

    // A write to x0 is architecturally invisible, so it never counts as a producer
    function automatic logic writes_rd(input logic [31:0] i);
        return (i[6:0] inside {OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR})
               && (i[11:7] != 5'd0);
    endfunction

    function automatic logic uses_rs1(input logic [31:0] i);
        return i[6:0] inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    endfunction

    function automatic logic uses_rs2(input logic [31:0] i);
        return i[6:0] inside {OP_R, OP_STORE, OP_BRANCH};
    endfunction

    function automatic logic is_load(input logic [31:0] i);
        return i[6:0] == OP_LOAD;
    endfunction

    function automatic logic is_mem(input logic [31:0] i);
        return (i[6:0] == OP_LOAD) || (i[6:0] == OP_STORE);
    endfunction

endpackage

// File: rtl/rv_hazard_detect.sv
// Combinational hazard, flush and forwarding decisions from the current stage contents.
module rv_hazard_detect
    import rv_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic [31:0] i_d_instr,
    input  logic        i_d_valid,
    input  logic [31:0] i_x_instr,
    input  logic        i_x_valid,
    input  logic [31:0] i_m_instr,
    input  logic        i_m_valid,
    input  logic [31:0] i_w_instr,
    input  logic        i_w_valid,
    input  logic        i_br_taken,
    input  logic        i_dmem_ready,
    output logic        o_mem_wait,
    output logic        o_flush,
    output logic        o_hold,
    output logic        o_pc_stall,
    output logic [1:0]  o_fwd_a_sel,
    output logic [1:0]  o_fwd_b_sel
);

    // Does a valid producer's rd collide with a source the D instruction actually reads?
    function automatic logic d_hit(input logic [31:0] prod, input logic pv, input logic [31:0] d);
        return pv && writes_rd(prod) &&
               ((uses_rs1(d) && rd_of(prod) == rs1_of(d)) ||
                (uses_rs2(d) && rd_of(prod) == rs2_of(d)));
    endfunction

    // Youngest producer wins: M before W; x0 is never bypassed
    function automatic logic [1:0] fwd_pick(input logic [4:0] rs,
                                            input logic [31:0] mi, input logic mv,
                                            input logic [31:0] wi, input logic wv);
        if (rs == 5'd0)                                 return FWD_RF;
        if (mv && writes_rd(mi) && rd_of(mi) == rs)     return FWD_MEM;
        if (wv && writes_rd(wi) && rd_of(wi) == rs)     return FWD_WB;
        return FWD_RF;
    endfunction

    logic w_hit_x, w_hit_m, w_hit_w, w_raw;

    assign w_hit_x = i_d_valid && d_hit(i_x_instr, i_x_valid, i_d_instr);
    assign w_hit_m = i_d_valid && d_hit(i_m_instr, i_m_valid, i_d_instr);
    assign w_hit_w = i_d_valid && d_hit(i_w_instr, i_w_valid, i_d_instr);

    // With bypassing only a load in X is too late; without it any in-flight writer blocks D
    assign w_raw = (FWD_EN != 0) ? (w_hit_x && is_load(i_x_instr))
                                 : (w_hit_x || w_hit_m || w_hit_w);

    // Memory wait outranks a redirect, which outranks a data-hazard hold
    assign o_mem_wait = i_m_valid && is_mem(i_m_instr) && !i_dmem_ready;
    assign o_flush    = !o_mem_wait && i_x_valid && i_br_taken;
    assign o_hold     = !o_mem_wait && !o_flush && w_raw;
    assign o_pc_stall = o_mem_wait || o_hold;

    assign o_fwd_a_sel = (FWD_EN != 0) ? fwd_pick(rs1_of(i_x_instr), i_m_instr, i_m_valid,
                                                  i_w_instr, i_w_valid) : FWD_RF;
    assign o_fwd_b_sel = (FWD_EN != 0) ? fwd_pick(rs2_of(i_x_instr), i_m_instr, i_m_valid,
                                                  i_w_instr, i_w_valid) : FWD_RF;

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Five-stage pipeline control: stage registers, hold/bubble sequencing and perf counters.
module rv_pipe_ctrl
    import rv_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          FWD_EN    = 1,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  f_pc,
    input  logic [31:0]      f_instr,
    input  logic             br_taken,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic [XLEN-1:0]  d_pc,
    output logic [XLEN-1:0]  x_pc,
    output logic [XLEN-1:0]  m_pc,
    output logic [31:0]      d_instr,
    output logic [31:0]      x_instr,
    output logic [31:0]      m_instr,
    output logic [31:0]      w_instr,
    output logic             d_valid,
    output logic             x_valid,
    output logic             m_valid,
    output logic             w_valid,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [XLEN-1:0]  r_d_pc, r_x_pc, r_m_pc;
    logic [31:0]      r_d_instr, r_x_instr, r_m_instr, r_w_instr;
    logic             r_d_valid, r_x_valid, r_m_valid, r_w_valid;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic w_mem_wait, w_flush, w_hold, w_pc_stall;

    rv_hazard_detect #(.FWD_EN(FWD_EN)) u_hazard (
        .i_d_instr    (r_d_instr),
        .i_d_valid    (r_d_valid),
        .i_x_instr    (r_x_instr),
        .i_x_valid    (r_x_valid),
        .i_m_instr    (r_m_instr),
        .i_m_valid    (r_m_valid),
        .i_w_instr    (r_w_instr),
        .i_w_valid    (r_w_valid),
        .i_br_taken   (br_taken),
        .i_dmem_ready (dmem_ready),
        .o_mem_wait   (w_mem_wait),
        .o_flush      (w_flush),
        .o_hold       (w_hold),
        .o_pc_stall   (w_pc_stall),
        .o_fwd_a_sel  (fwd_a_sel),
        .o_fwd_b_sel  (fwd_b_sel)
    );

    // Stage advance: a memory wait freezes D/X/M and drains W; otherwise M and W always
    // move, X takes a bubble on flush or hold, D takes a bubble on flush and freezes on hold.
    // Bubbled stages keep their old PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_pc    <= '0;         r_x_pc    <= '0;         r_m_pc    <= '0;
            r_d_instr <= NOP_INSTR;  r_x_instr <= NOP_INSTR;
            r_m_instr <= NOP_INSTR;  r_w_instr <= NOP_INSTR;
            r_d_valid <= 1'b0;       r_x_valid <= 1'b0;
            r_m_valid <= 1'b0;       r_w_valid <= 1'b0;
        end else if (w_mem_wait) begin
            r_w_instr <= NOP_INSTR;
            r_w_valid <= 1'b0;
        end else begin
            r_w_instr <= r_m_instr;
            r_w_valid <= r_m_valid;
            r_m_pc    <= r_x_pc;
            r_m_instr <= r_x_instr;
            r_m_valid <= r_x_valid;
            if (w_flush || w_hold) begin
                r_x_instr <= NOP_INSTR;
                r_x_valid <= 1'b0;
            end else begin
                r_x_pc    <= r_d_pc;
                r_x_instr <= r_d_instr;
                r_x_valid <= r_d_valid;
            end
            if (w_flush) begin
                r_d_instr <= NOP_INSTR;
                r_d_valid <= 1'b0;
            end else if (!w_hold) begin
                r_d_pc    <= f_pc;
                r_d_instr <= f_instr;
                r_d_valid <= 1'b1;
            end
        end
    end

    // Saturating stall / flush event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pc_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign pc_stall  = w_pc_stall;
    assign d_pc      = r_d_pc;
    assign x_pc      = r_x_pc;
    assign m_pc      = r_m_pc;
    assign d_instr   = r_d_instr;
    assign x_instr   = r_x_instr;
    assign m_instr   = r_m_instr;
    assign w_instr   = r_w_instr;
    assign d_valid   = r_d_valid;
    assign x_valid   = r_x_valid;
    assign m_valid   = r_m_valid;
    assign w_valid   = r_w_valid;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed bench: one forwarding instance and one stall-only instance share stimulus.
module tb_rv_pipe_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADD1 = 32'h0031_00B3;   // add x1,x2,x3
    localparam logic [31:0] SUB4 = 32'h4050_8233;   // sub x4,x1,x5
    localparam logic [31:0] LW6  = 32'h0000_2303;   // lw  x6,0(x0)
    localparam logic [31:0] ADD7 = 32'h0063_03B3;   // add x7,x6,x6
    localparam logic [31:0] BEQ  = 32'h0000_0063;   // beq x0,x0,0
    localparam logic [31:0] SW0  = 32'h0000_2023;   // sw  x0,0(x0)
    localparam logic [31:0] OR2  = 32'h0010_E133;   // or  x2,x1,x1

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] f_pc = '0, f_instr = NOP;
    logic        br_taken = 1'b0, dmem_ready = 1'b1;

    // forwarding instance (a_*) and stall-only instance (s_*)
    logic        a_pc_stall, s_pc_stall;
    logic [31:0] a_d_pc, a_x_pc, a_m_pc, s_d_pc, s_x_pc, s_m_pc;
    logic [31:0] a_d_instr, a_x_instr, a_m_instr, a_w_instr;
    logic [31:0] s_d_instr, s_x_instr, s_m_instr, s_w_instr;
    logic        a_d_valid, a_x_valid, a_m_valid, a_w_valid;
    logic        s_d_valid, s_x_valid, s_m_valid, s_w_valid;
    logic [1:0]  a_fwd_a, a_fwd_b, s_fwd_a, s_fwd_b;
    logic [15:0] a_stall_cnt, a_flush_cnt, s_stall_cnt, s_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv_pipe_ctrl #(.FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_instr(f_instr),
        .br_taken(br_taken), .dmem_ready(dmem_ready), .pc_stall(a_pc_stall),
        .d_pc(a_d_pc), .x_pc(a_x_pc), .m_pc(a_m_pc),
        .d_instr(a_d_instr), .x_instr(a_x_instr), .m_instr(a_m_instr), .w_instr(a_w_instr),
        .d_valid(a_d_valid), .x_valid(a_x_valid), .m_valid(a_m_valid), .w_valid(a_w_valid),
        .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    rv_pipe_ctrl #(.FWD_EN(0)) u_stl (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_instr(f_instr),
        .br_taken(br_taken), .dmem_ready(dmem_ready), .pc_stall(s_pc_stall),
        .d_pc(s_d_pc), .x_pc(s_x_pc), .m_pc(s_m_pc),
        .d_instr(s_d_instr), .x_instr(s_x_instr), .m_instr(s_m_instr), .w_instr(s_w_instr),
        .d_valid(s_d_valid), .x_valid(s_x_valid), .m_valid(s_m_valid), .w_valid(s_w_valid),
        .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
        f_pc    = pc;
        f_instr = ins;
    endtask

    task automatic do_reset();
        rst = 1'b1; br_taken = 1'b0; dmem_ready = 1'b1;
        fetch(32'h0, NOP);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        // ---- reset state, then add -> sub bypass from M ----
        do_reset();
        fetch(32'h100, ADD1);
        #1;
        chk("rst_valids", {a_d_valid, a_x_valid, a_m_valid, a_w_valid}, 4'b0000);
        chk("rst_x_instr", a_x_instr, NOP);
        chk("rst_w_instr", a_w_instr, NOP);
        chk("rst_d_pc", a_d_pc, 32'h0);
        chk("rst_cnts", {a_stall_cnt, a_flush_cnt}, 32'h0);
        chk("rst_pc_stall", a_pc_stall, 1'b0);
        chk("rst_fwd", {a_fwd_a, a_fwd_b}, 4'b0000);
        cyc(); fetch(32'h104, SUB4);
        cyc(); fetch(32'h108, NOP);
        cyc(); #1;
        chk("byp_x_instr", a_x_instr, SUB4);
        chk("byp_x_pc", a_x_pc, 32'h104);
        chk("byp_fwd_a", a_fwd_a, 2'd1);
        chk("byp_fwd_b", a_fwd_b, 2'd0);
        chk("byp_no_stall", a_pc_stall, 1'b0);
        cyc(); #1;
        chk("byp_w_instr", a_w_instr, ADD1);
        chk("byp_w_valid", a_w_valid, 1'b1);
        chk("byp_m_pc", a_m_pc, 32'h104);
        chk("byp_stall_cnt", a_stall_cnt, 16'd0);

        // ---- load-use: one bubble then bypass both operands from W ----
        do_reset();
        fetch(32'h200, LW6);  cyc();
        fetch(32'h204, ADD7); cyc(); #1;
        chk("lu_x_lw", a_x_instr, LW6);
        chk("lu_stall", a_pc_stall, 1'b1);
        fetch(32'h208, NOP); cyc(); #1;
        chk("lu_stall_off", a_pc_stall, 1'b0);
        chk("lu_x_bubble", a_x_instr, NOP);
        chk("lu_x_valid", a_x_valid, 1'b0);
        chk("lu_d_held", a_d_instr, ADD7);
        chk("lu_stall_cnt", a_stall_cnt, 16'd1);
        cyc(); #1;
        chk("lu_x_add", a_x_instr, ADD7);
        chk("lu_fwd_a", a_fwd_a, 2'd2);
        chk("lu_fwd_b", a_fwd_b, 2'd2);
        chk("lu_stall_cnt2", a_stall_cnt, 16'd1);

        // ---- taken branch flush, then br_taken with empty X ignored ----
        do_reset();
        fetch(32'h300, BEQ); cyc();
        fetch(32'h304, NOP); cyc();
        br_taken = 1'b1; #1;
        chk("fl_x_beq", a_x_instr, BEQ);
        chk("fl_pc_stall", a_pc_stall, 1'b0);
        fetch(32'h400, NOP); cyc(); #1;
        chk("fl_dx_valid", {a_d_valid, a_x_valid}, 2'b00);
        chk("fl_m_beq", a_m_instr, BEQ);
        chk("fl_cnt", a_flush_cnt, 16'd1);
        cyc(); #1;
        chk("fl_ignored_cnt", a_flush_cnt, 16'd1);
        chk("fl_ignored_d", {31'd0, a_d_valid}, 32'd1);
        chk("fl_ignored_dpc", a_d_pc, 32'h400);
        br_taken = 1'b0;

        // ---- store in M with three wait cycles ----
        do_reset();
        fetch(32'h500, SW0);  cyc();
        fetch(32'h504, ADD1); cyc();
        fetch(32'h508, NOP);  cyc();
        dmem_ready = 1'b0; #1;
        chk("mw_m_sw", a_m_instr, SW0);
        chk("mw_pc_stall", a_pc_stall, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            cyc(); #1;
            chk("mw_d_pc", a_d_pc, 32'h508);
            chk("mw_x_held", a_x_instr, ADD1);
            chk("mw_m_held", a_m_instr, SW0);
            chk("mw_w_bubble", a_w_valid, 1'b0);
            chk("mw_stall_cnt", a_stall_cnt, 16'(k));
        end
        dmem_ready = 1'b1; #1;
        chk("mw_release", a_pc_stall, 1'b0);
        cyc(); #1;
        chk("mw_adv_m", a_m_instr, ADD1);
        chk("mw_adv_w", a_w_instr, SW0);
        chk("mw_adv_wv", a_w_valid, 1'b1);
        chk("mw_final_cnt", a_stall_cnt, 16'd3);

        // ---- reset during a memory wait ----
        do_reset();
        fetch(32'h500, SW0);  cyc();
        fetch(32'h504, ADD1); cyc();
        fetch(32'h508, NOP);  cyc();
        dmem_ready = 1'b0;
        cyc(); cyc(); #1;
        chk("rw_pre_cnt", a_stall_cnt, 16'd2);
        rst = 1'b1; cyc(); rst = 1'b0; #1;
        chk("rw_valids", {a_d_valid, a_x_valid, a_m_valid, a_w_valid}, 4'b0000);
        chk("rw_cnts", {a_stall_cnt, a_flush_cnt}, 32'h0);
        chk("rw_m_instr", a_m_instr, NOP);
        chk("rw_pc_stall", a_pc_stall, 1'b0);
        dmem_ready = 1'b1;

        // ---- stall-only mode: add x1 then or x2,x1,x1 ----
        do_reset();
        fetch(32'h600, ADD1); cyc();
        fetch(32'h604, OR2);  cyc(); #1;
        chk("so_stall_x", s_pc_stall, 1'b1);
        chk("so_fwd_no_stall", a_pc_stall, 1'b0);
        fetch(32'h608, NOP); cyc(); #1;
        chk("so_stall_m", s_pc_stall, 1'b1);
        chk("so_d_held", s_d_instr, OR2);
        chk("so_x_bubble", s_x_valid, 1'b0);
        chk("so_fwd_zero", {s_fwd_a, s_fwd_b}, 4'b0000);
        chk("so_fwdmode_x", a_x_instr, OR2);
        chk("so_fwdmode_sel", {a_fwd_a, a_fwd_b}, 4'b0101);
        cyc(); #1;
        chk("so_stall_w", s_pc_stall, 1'b1);
        cyc(); #1;
        chk("so_stall_done", s_pc_stall, 1'b0);
        chk("so_stall_cnt", s_stall_cnt, 16'd3);
        cyc(); #1;
        chk("so_x_or", s_x_instr, OR2);
        chk("so_fwd_final", {s_fwd_a, s_fwd_b}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
